// File: rtl/scroll_text_gen.sv
// Scrolling 8-digit text window over a 16-entry message buffer.
// A free-running prescaler steps the window; writes are accepted only while paused.
module scroll_text_gen #(
    parameter int BEAT_WIDTH = 27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        select,
    input  logic        pause,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [4:0]  wr_data,
    output logic        wr_ack,
    output logic        beat,
    output logic [3:0]  offset,
    output logic [39:0] chars
);

    // Offset-0 window of the reset message, digit 7 in the top bits.
    localparam logic [39:0] RESET_WINDOW = {5'h1F, 5'h1F, 5'h1F, 5'h00,
                                            5'h11, 5'h11, 5'h0E, 5'h10};

    logic [BEAT_WIDTH-1:0] prescaler;
    logic [4:0]            msg [16];
    logic [39:0]           window;
    logic                  wrap;

    assign wrap = !pause && (&prescaler);

    always_comb begin
        window = '0;
        for (int k = 0; k < 8; k++) begin
            window[5*k +: 5] = msg[4'(offset + 4'(k))];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            offset    <= '0;
            beat      <= 1'b0;
            wr_ack    <= 1'b0;
            chars     <= RESET_WINDOW;
            msg[0]    <= 5'h10;
            msg[1]    <= 5'h0E;
            msg[2]    <= 5'h11;
            msg[3]    <= 5'h11;
            msg[4]    <= 5'h00;
            for (int i = 5; i < 16; i++) begin
                msg[i] <= 5'h1F;
            end
        end else begin
            if (!pause) begin
                prescaler <= prescaler + 1'b1;
            end
            beat <= wrap;
            if (wrap) begin
                offset <= select ? offset - 4'd1 : offset + 4'd1;
            end
            wr_ack <= wr_en && pause;
            if (wr_en && pause) begin
                msg[wr_addr] <= wr_data;
            end
            // Window lags offset/msg by one cycle, so a write shows two cycles later.
            chars <= window;
        end
    end

endmodule

// File: tb/tb_scroll_text_gen.sv
// Self-checking bench for scroll_text_gen: directed scenarios plus random traffic
// compared every cycle against an arithmetic reference model.
module tb_scroll_text_gen;

    logic        clk = 1'b0;
    logic        reset, select, pause, wr_en;
    logic [3:0]  wr_addr;
    logic [4:0]  wr_data;
    logic        wr_ack, beat;
    logic [3:0]  offset;
    logic [39:0] chars;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          m_cnt, m_off;
    logic [4:0]  m_msg [16];
    logic        m_beat, m_ack;
    logic [39:0] m_chars;
    int          cyc_no = 0;

    scroll_text_gen #(.BEAT_WIDTH(3)) dut (
        .clk(clk), .reset(reset), .select(select), .pause(pause),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .beat(beat), .offset(offset), .chars(chars)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc_no);
        end
    endtask

    function automatic logic [39:0] win(input int off);
        logic [39:0] w;
        for (int k = 0; k < 8; k++) w[5*k +: 5] = m_msg[(off + k) % 16];
        return w;
    endfunction

    function automatic logic [4:0] digit(input logic [39:0] c, input int k);
        return c[5*k +: 5];
    endfunction

    // One clock: advance model with the inputs present at the edge, then compare.
    task automatic cyc();
        logic [39:0] nxt;
        @(posedge clk);
        cyc_no++;
        if (reset) begin
            m_cnt = 0; m_off = 0; m_beat = 0; m_ack = 0;
            m_msg[0] = 5'h10; m_msg[1] = 5'h0E; m_msg[2] = 5'h11;
            m_msg[3] = 5'h11; m_msg[4] = 5'h00;
            for (int i = 5; i < 16; i++) m_msg[i] = 5'h1F;
            m_chars = win(0);
        end else begin
            nxt    = win(m_off);
            m_beat = !pause && (m_cnt == 7);
            if (m_beat) m_off = select ? (m_off + 15) % 16 : (m_off + 1) % 16;
            if (!pause) m_cnt = (m_cnt + 1) % 8;
            m_ack = wr_en && pause;
            if (m_ack) m_msg[wr_addr] = wr_data;
            m_chars = nxt;
        end
        #1;
        chk("beat",   40'(beat),   40'(m_beat));
        chk("offset", 40'(offset), 40'(m_off));
        chk("wr_ack", 40'(wr_ack), 40'(m_ack));
        chk("chars",  chars,       m_chars);
    endtask

    task automatic do_reset();
        reset = 1'b1; wr_en = 1'b0; pause = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
    endtask

    localparam logic [39:0] HELLO = {5'h1F, 5'h1F, 5'h1F, 5'h00, 5'h11, 5'h11, 5'h0E, 5'h10};

    initial begin
        int beats, last_beat, pos;
        reset = 1'b1; select = 1'b0; pause = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        // Reset state and first left beat
        do_reset();
        chk("reset_chars", chars, HELLO);
        chk("reset_off", 40'(offset), 40'd0);
        beats = 0;
        for (int i = 0; i < 8; i++) begin cyc(); beats += int'(beat); end
        chk("first_beat_cnt", 40'(beats), 40'd1);
        chk("first_beat_off", 40'(offset), 40'd1);
        cyc();
        chk("left_digit0", 40'(digit(chars, 0)), 40'h0E);

        // Right scroll from reset
        do_reset();
        select = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        chk("right_off", 40'(offset), 40'd15);
        cyc();
        chk("right_digit0", 40'(digit(chars, 0)), 40'h1F);
        chk("right_digit1", 40'(digit(chars, 1)), 40'h10);

        // 16 left beats wrap back to the reset window, evenly spaced
        do_reset();
        select = 1'b0; last_beat = -1;
        for (int i = 0; i < 128; i++) begin
            cyc();
            if (beat) begin
                if (last_beat >= 0) chk("beat_spacing", 40'(i - last_beat), 40'd8);
                last_beat = i;
            end
        end
        chk("wrap_off", 40'(offset), 40'd0);
        cyc();
        chk("wrap_chars", chars, HELLO);

        // Pause with prescaler at 7: frozen, then beat right after release
        do_reset();
        for (int i = 0; i < 7; i++) cyc();
        pause = 1'b1; beats = 0;
        for (int i = 0; i < 20; i++) begin cyc(); beats += int'(beat); end
        chk("paused_beats", 40'(beats), 40'd0);
        pause = 1'b0;
        cyc();
        chk("release_beat", 40'(beat), 40'd1);
        chk("release_off", 40'(offset), 40'd1);

        // Paused write visible two cycles later; unpaused write ignored
        do_reset();
        pause = 1'b1; wr_en = 1'b1; wr_addr = 4'd5; wr_data = 5'h12;
        cyc();
        wr_en = 1'b0;
        chk("wr_ack_paused", 40'(wr_ack), 40'd1);
        cyc();
        chk("wr_digit5", 40'(digit(chars, 5)), 40'h12);
        pause = 1'b0; wr_en = 1'b1; wr_addr = 4'd6;
        cyc();
        wr_en = 1'b0;
        chk("wr_ack_unpaused", 40'(wr_ack), 40'd0);
        cyc();
        chk("unpaused_digit6", 40'(digit(chars, 6)), 40'h1F);

        // Back-to-back paused writes
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 4'(8 + i); wr_data = 5'(i);
            cyc();
            chk("b2b_ack", 40'(wr_ack), 40'd1);
        end
        wr_en = 1'b0; pause = 1'b0;

        // Reset mid-count at offset 9 with a pending write
        do_reset();
        for (int i = 0; i < 75; i++) cyc();
        chk("pre_reset_off", 40'(offset), 40'd9);
        reset = 1'b1; pause = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 5'h13;
        cyc();
        chk("rst_off", 40'(offset), 40'd0);
        chk("rst_ack", 40'(wr_ack), 40'd0);
        chk("rst_chars", chars, HELLO);
        reset = 1'b0; pause = 1'b0; wr_en = 1'b0;
        pos = 0;
        for (int i = 0; i < 8; i++) begin cyc(); if (beat) pos = i + 1; end
        chk("rst_presc_zero", 40'(pos), 40'd8);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            reset   = ($urandom_range(0, 99) == 0);
            select  = 1'($urandom);
            pause   = ($urandom_range(0, 2) == 0);
            wr_en   = 1'($urandom);
            wr_addr = 4'($urandom);
            wr_data = 5'($urandom);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/scroll_text_gen.md
SCROLL_TEXT_GEN -- requirements
Module: scroll_text_gen

Interface
REQ-001 SHALL have parameter BEAT_WIDTH, default 27, prescaler counter width; a beat occurs every 2^BEAT_WIDTH unpaused cycles.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port select  input  1  scroll direction: 0 = left (offset increments), 1 = right (offset decrements).
REQ-005 SHALL have port pause  input  1  1 = freeze prescaler and offset, and enable message writes.
REQ-006 SHALL have port wr_en  input  1  message write request.
REQ-007 SHALL have port wr_addr  input  4  message slot 0..15.
REQ-008 SHALL have port wr_data  input  5  character code.
REQ-009 SHALL have port wr_ack  output  1  one-cycle pulse: write accepted.
REQ-010 SHALL have port beat  output  1  one-cycle pulse on each scroll step.
REQ-011 SHALL have port offset  output  4  current window start index.
REQ-012 SHALL have port chars  output  40  eight 5-bit codes; chars[5k+4:5k] drives display digit k (k=0 rightmost).

Function
REQ-013 SHALL hold a 16-entry x 5-bit message buffer msg[0..15].
REQ-014 SHALL use character codes: 0x00-0x0F hex digits, 0x10 'H', 0x11 'L', 0x12 'P', 0x13 '-', 0x1F blank; other codes are passed through unchanged.
REQ-015 SHALL run a BEAT_WIDTH-bit prescaler that increments each cycle while pause=0 and holds while pause=1.
REQ-016 SHALL, on the edge where the prescaler wraps from all-ones to 0, update offset and assert beat for exactly the following cycle.
REQ-017 SHALL update offset to (offset+1) mod 16 when select=0 and to (offset-1) mod 16 when select=1, sampling select at the wrap edge; 15->0 and 0->15 wrap with no gap.
REQ-018 SHALL give pause priority: when pause=1 in the would-be wrap cycle, no wrap, no beat, and offset unchanged.
REQ-019 SHALL drive chars digit k = msg[(offset+k) mod 16], registered, reflecting offset/msg state one cycle after any change.
REQ-020 SHALL, when wr_en=1 and pause=1, write msg[wr_addr] <= wr_data and assert wr_ack the next cycle.
REQ-021 SHALL ignore wr_en when pause=0: msg unchanged and wr_ack=0.
REQ-022 SHALL allow back-to-back writes every cycle while paused, each acknowledged individually.
REQ-023 SHALL, for a write to a slot currently in the window, show the new code on chars two cycles after the write cycle.

Reset
REQ-024 SHALL, while reset=1 at a clock edge, set prescaler=0, offset=0, beat=0, and wr_ack=0.
REQ-025 SHALL, on reset, load msg[0..4] = 0x10,0x0E,0x11,0x11,0x00 ("HELLO") and msg[5..15] = 0x1F.
REQ-026 SHALL, on reset, load chars directly with the offset-0 window: digits 0..7 = 10,0E,11,11,00,1F,1F,1F.
REQ-027 SHALL give reset priority over pause, wr_en, and prescaler wrap, including mid-operation.

Verification
REQ-028 SHALL run the bench with BEAT_WIDTH=3.
REQ-029 Scenario: reset, select=0, pause=0, 8 cycles -> beat pulses once; offset=1; chars digit0=0x0E one cycle later.
REQ-030 Scenario: select=1 from reset, first beat -> offset=15; digit0=0x1F and digit1=0x10.
REQ-031 Scenario: select=0 for 16 beats -> offset returns to 0 with chars equal to the reset window; beats exactly 8 cycles apart.
REQ-032 Scenario: pause=1 with prescaler=7 for 20 cycles, then release -> no beat while paused; beat 1 cycle after release; offset +1 only.
REQ-033 Scenario: pause=1, write addr 5 data 0x12 -> wr_ack next cycle; digit5=0x12 two cycles after the write; the same write with pause=0 -> no ack and msg unchanged.
REQ-034 Scenario: reset asserted at offset=9 mid-count with wr_en=1 -> offset=0, prescaler=0, wr_ack=0, and msg back to "HELLO".
